// File: rtl/tetromino_queue.sv
// tetromino_queue: active falling piece plus a preview queue of upcoming types.
//
// Holds the active piece (type, rotation, 4x4 bitmap, colour) and up to
// QUEUE_DEPTH preview types. The queue is refilled from a 16-bit Galois LFSR,
// drawing uniformly or from a 7-bag. A combinational rotation candidate is
// offered to the collision checker, which approves it with rotate_en.
//
// Ports:
//   clk             single clock, all state on rising edge
//   reset           synchronous, active-high
//   load_next_block pop the queue head into the active piece
//   rotate          rotation request
//   rotate_dir      0 = clockwise, 1 = counter-clockwise
//   rotate_en       collision checker approves rot_candidate this cycle
//   rot_candidate   bitmap of the requested rotation (combinational)
//   block           active bitmap, row-major, bit15 = row0/col0
//   block_type      I=1 O=2 S=3 Z=4 J=5 L=6 T=7
//   block_rot       rotation index 0..3
//   block_color     colour of the active piece
//   preview_types   preview queue, head in [2:0], empty slots read 0
//   queue_count     number of valid preview entries
module tetromino_queue #(
    parameter int          QUEUE_DEPTH = 3,
    parameter bit          BAG_MODE    = 1'b0,
    parameter bit          COLOR_MODE  = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_next_block,
    input  logic                     rotate,
    input  logic                     rotate_dir,
    input  logic                     rotate_en,
    output logic [15:0]              rot_candidate,
    output logic [15:0]              block,
    output logic [2:0]               block_type,
    output logic [1:0]               block_rot,
    output logic [2:0]               block_color,
    output logic [3*QUEUE_DEPTH-1:0] preview_types,
    output logic [2:0]               queue_count
);

    typedef enum logic [2:0] {
        PIECE_NONE = 3'd0,
        PIECE_I    = 3'd1,
        PIECE_O    = 3'd2,
        PIECE_S    = 3'd3,
        PIECE_Z    = 3'd4,
        PIECE_J    = 3'd5,
        PIECE_L    = 3'd6,
        PIECE_T    = 3'd7
    } piece_e;

    // An all-zero seed would lock the LFSR up forever.
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [2:0]  DEPTH     = 3'(QUEUE_DEPTH);

    function automatic logic [15:0] shape(input logic [2:0] t, input logic [1:0] r);
        logic [15:0] s;
        s = 16'h0000;
        case (t)
            PIECE_I: s = r[0] ? 16'h2222 : 16'hF000;
            PIECE_O: s = 16'h6600;
            PIECE_S: s = r[0] ? 16'h4620 : 16'h6C00;
            PIECE_Z: s = r[0] ? 16'h2640 : 16'hC600;
            PIECE_J: case (r)
                         2'd0:    s = 16'h8E00;
                         2'd1:    s = 16'hC880;
                         2'd2:    s = 16'hE200;
                         default: s = 16'h2260;
                     endcase
            PIECE_L: case (r)
                         2'd0:    s = 16'h2E00;
                         2'd1:    s = 16'h4460;
                         2'd2:    s = 16'hE800;
                         default: s = 16'h6220;
                     endcase
            PIECE_T: case (r)
                         2'd0:    s = 16'h4E00;
                         2'd1:    s = 16'h4640;
                         2'd2:    s = 16'h0E40;
                         default: s = 16'h4C40;
                     endcase
            default: s = 16'h0000;
        endcase
        return s;
    endfunction

    logic [15:0] lfsr;
    logic [6:0]  bag;          // bit (t-1) set once type t was pushed from this bag
    logic [6:0]  bag_d;
    logic [6:0]  bag_set;
    logic [2:0]  color_cnt;
    logic [2:0]  queue_q [QUEUE_DEPTH];
    logic [2:0]  queue_d [QUEUE_DEPTH];
    logic [2:0]  count_d;
    logic [2:0]  tail;
    logic [2:0]  draw;
    logic [1:0]  cand_rot;
    logic        commit;
    logic        pop;
    logic        in_bag;
    logic        draw_valid;
    logic        push;

    assign draw          = lfsr[2:0];
    assign cand_rot      = rotate_dir ? (block_rot - 2'd1) : (block_rot + 2'd1);
    assign rot_candidate = shape(block_type, cand_rot);

    // A committed rotation wins over a load; the load is then dropped.
    assign commit     = rotate && rotate_en;
    assign pop        = load_next_block && !commit && (queue_count != 3'd0);
    // draw - 1 wraps to 7 when draw is 0, shifting the bit out; draw 0 is invalid anyway.
    assign in_bag     = |(bag & (7'd1 << (draw - 3'd1)));
    assign bag_set    = bag | (7'd1 << (draw - 3'd1));
    assign draw_valid = (draw != 3'd0) && !(BAG_MODE && in_bag);
    assign push       = draw_valid && ((queue_count < DEPTH) || pop);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            queue_d[i] = queue_q[i];
        end
        count_d = queue_count;
        tail    = queue_count;
        bag_d   = bag;

        if (pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                queue_d[i] = queue_q[i + 1];
            end
            queue_d[QUEUE_DEPTH-1] = 3'd0;
            tail = queue_count - 3'd1;
        end

        // With a simultaneous pop the new entry lands in the slot the shift just freed.
        if (push) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (3'(i) == tail) begin
                    queue_d[i] = draw;
                end
            end
            if (BAG_MODE) begin
                bag_d = (bag_set == 7'h7F) ? 7'h00 : bag_set;
            end
        end

        if (push && !pop) begin
            count_d = queue_count + 3'd1;
        end else if (pop && !push) begin
            count_d = queue_count - 3'd1;
        end
    end

    always_comb begin
        preview_types = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            preview_types[3*i +: 3] = queue_q[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr        <= SEED;
            // NOTE: the preview storage is reset explicitly because empty slots must read 0.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= 3'd0;
            end
            queue_count <= 3'd0;
            bag         <= 7'h00;
            block       <= 16'hF000;
            block_type  <= PIECE_I;
            block_rot   <= 2'd0;
            block_color <= COLOR_MODE ? 3'd4 : 3'd1;
            color_cnt   <= 3'd4;
        end else begin
            lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
            queue_q     <= queue_d;
            queue_count <= count_d;
            bag         <= bag_d;

            if (commit) begin
                block_rot <= cand_rot;
                block     <= rot_candidate;
            end else if (pop) begin
                block_type <= queue_q[0];
                block_rot  <= 2'd0;
                block      <= shape(queue_q[0], 2'd0);
                if (COLOR_MODE) begin
                    block_color <= color_cnt;
                    color_cnt   <= (color_cnt == 3'd7) ? 3'd1 : (color_cnt + 3'd1);
                end else begin
                    block_color <= queue_q[0];
                end
            end
        end
    end

endmodule
